// File: rtl/eth_frame_write_func.sv
// Ethernet frame writer: latches a header and payload length on start, hands the header
// to eth_axis_tx, then streams payload beats with optional zero padding and a done pulse.
module eth_frame_write_func #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned PAD_EN     = 1,
  parameter int unsigned MIN_LEN    = 46
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  input  logic [47:0]               dest_mac,
  input  logic [47:0]               src_mac,
  input  logic [15:0]               eth_type,
  input  logic [LEN_WIDTH-1:0]      payload_len,
  input  logic [DATA_WIDTH-1:0]     in_tdata,
  input  logic                      in_tvalid,
  input  logic                      in_tuser,
  output logic                      in_tready,
  input  logic                      tx_busy,
  output logic                      tx_s_eth_hdr_valid,
  input  logic                      tx_s_eth_hdr_ready,
  output logic [47:0]               tx_s_eth_dest_mac,
  output logic [47:0]               tx_s_eth_src_mac,
  output logic [15:0]               tx_s_eth_type,
  output logic [DATA_WIDTH-1:0]     tx_s_eth_payload_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   tx_s_eth_payload_axis_tkeep,
  output logic                      tx_s_eth_payload_axis_tvalid,
  input  logic                      tx_s_eth_payload_axis_tready,
  output logic                      tx_s_eth_payload_axis_tlast,
  output logic                      tx_s_eth_payload_axis_tuser,
  output logic                      valid
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);
  localparam logic [LEN_WIDTH-1:0] FLOOR_L = (PAD_EN != 0) ? LEN_WIDTH'(MIN_LEN) : LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_e;

  state_e                state_q;
  logic                  hdr_valid_q;
  logic [47:0]           dest_q;
  logic [47:0]           src_q;
  logic [15:0]           type_q;
  logic [LEN_WIDTH-1:0]  real_rem_q;
  logic [LEN_WIDTH-1:0]  el_rem_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [BYTES-1:0]      tkeep_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  tuser_q;
  logic                  valid_q;

  logic                  hdr_fire;
  logic                  slot_free;
  logic                  load_win;
  logic                  is_real;
  logic                  is_last;
  logic                  load;
  logic                  beat_err;
  logic [DATA_WIDTH-1:0] beat_data_d;
  logic [BYTES-1:0]      beat_keep_d;
  logic [LEN_WIDTH-1:0]  real_rem_d;
  logic [LEN_WIDTH-1:0]  el_rem_d;
  logic [LEN_WIDTH-1:0]  el_start;

  // Beat formation. real_rem/el_rem count real and effective bytes still to send; the
  // header handshake cycle doubles as the first load slot so beat 0 follows it directly.
  always_comb begin
    hdr_fire    = hdr_valid_q && tx_s_eth_hdr_ready;
    slot_free   = !tvalid_q || tx_s_eth_payload_axis_tready;
    load_win    = ((state_q == S_PAYLOAD) || ((state_q == S_HDR) && hdr_fire))
                  && slot_free && (el_rem_q != '0);
    is_real     = (real_rem_q != '0);
    is_last     = (el_rem_q <= BYTES_L);
    in_tready   = load_win && is_real;
    load        = load_win && (!is_real || in_tvalid);
    beat_err    = err_q || (in_tready && in_tvalid && in_tuser);
    real_rem_d  = (real_rem_q > BYTES_L) ? (real_rem_q - BYTES_L) : '0;
    el_rem_d    = is_last ? '0 : (el_rem_q - BYTES_L);
    el_start    = (payload_len > FLOOR_L) ? payload_len : FLOOR_L;
    beat_data_d = '0;
    beat_keep_d = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      beat_data_d[8*b +: 8] = (is_real && (LEN_WIDTH'(b) < real_rem_q)) ? in_tdata[8*b +: 8] : 8'h00;
      beat_keep_d[b]        = !is_last || (LEN_WIDTH'(b) < el_rem_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_valid_q <= 1'b0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      real_rem_q  <= '0;
      el_rem_q    <= '0;
      err_q       <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !tx_busy) begin
            dest_q      <= dest_mac;
            src_q       <= src_mac;
            type_q      <= eth_type;
            real_rem_q  <= payload_len;
            el_rem_q    <= el_start;
            err_q       <= 1'b0;
            hdr_valid_q <= 1'b1;
            state_q     <= S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_fire) begin
            hdr_valid_q <= 1'b0;
            state_q     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (tvalid_q && tx_s_eth_payload_axis_tready && tlast_q) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Output register: refill on an empty or draining slot, otherwise hold until tready.
      if (load) begin
        tdata_q    <= beat_data_d;
        tkeep_q    <= beat_keep_d;
        tvalid_q   <= 1'b1;
        tlast_q    <= is_last;
        tuser_q    <= is_last && beat_err;
        err_q      <= beat_err;
        real_rem_q <= real_rem_d;
        el_rem_q   <= el_rem_d;
      end else if (tvalid_q && tx_s_eth_payload_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end
    end
  end

  assign ready                        = (state_q == S_IDLE) && !tx_busy;
  assign tx_s_eth_hdr_valid           = hdr_valid_q;
  assign tx_s_eth_dest_mac            = dest_q;
  assign tx_s_eth_src_mac             = src_q;
  assign tx_s_eth_type                = type_q;
  assign tx_s_eth_payload_axis_tdata  = tdata_q;
  assign tx_s_eth_payload_axis_tkeep  = tkeep_q;
  assign tx_s_eth_payload_axis_tvalid = tvalid_q;
  assign tx_s_eth_payload_axis_tlast  = tlast_q;
  assign tx_s_eth_payload_axis_tuser  = tuser_q;
  assign valid                        = valid_q;

endmodule

// File: tb/tb_eth_frame_write_func.sv
// Bench for eth_frame_write_func: three configurations (8-bit no pad, 32-bit pad, 32-bit
// no pad) driven from a table of frames plus hand-written busy and reset sequences.
module tb_eth_frame_write_func;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  st;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type, payload_len;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tuser, tx_busy, hdr_ready, tready;

  logic [2:0]  rdy, itr, hv, tv, tl, tu, vld;
  logic [47:0] dm [3];
  logic [47:0] sm [3];
  logic [15:0] ty [3];
  logic [7:0]  td_a;
  logic [31:0] td_b, td_c;
  logic        kp_a;
  logic [3:0]  kp_b, kp_c;

  eth_frame_write_func #(.DATA_WIDTH(8), .LEN_WIDTH(16), .PAD_EN(0), .MIN_LEN(46)) u_a (
    .clk(clk), .rst(rst), .start(st[0]), .ready(rdy[0]),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type), .payload_len(payload_len),
    .in_tdata(in_tdata[7:0]), .in_tvalid(in_tvalid), .in_tuser(in_tuser), .in_tready(itr[0]),
    .tx_busy(tx_busy), .tx_s_eth_hdr_valid(hv[0]), .tx_s_eth_hdr_ready(hdr_ready),
    .tx_s_eth_dest_mac(dm[0]), .tx_s_eth_src_mac(sm[0]), .tx_s_eth_type(ty[0]),
    .tx_s_eth_payload_axis_tdata(td_a), .tx_s_eth_payload_axis_tkeep(kp_a),
    .tx_s_eth_payload_axis_tvalid(tv[0]), .tx_s_eth_payload_axis_tready(tready),
    .tx_s_eth_payload_axis_tlast(tl[0]), .tx_s_eth_payload_axis_tuser(tu[0]), .valid(vld[0]));

  eth_frame_write_func #(.DATA_WIDTH(32), .LEN_WIDTH(16), .PAD_EN(1), .MIN_LEN(46)) u_b (
    .clk(clk), .rst(rst), .start(st[1]), .ready(rdy[1]),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type), .payload_len(payload_len),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tuser(in_tuser), .in_tready(itr[1]),
    .tx_busy(tx_busy), .tx_s_eth_hdr_valid(hv[1]), .tx_s_eth_hdr_ready(hdr_ready),
    .tx_s_eth_dest_mac(dm[1]), .tx_s_eth_src_mac(sm[1]), .tx_s_eth_type(ty[1]),
    .tx_s_eth_payload_axis_tdata(td_b), .tx_s_eth_payload_axis_tkeep(kp_b),
    .tx_s_eth_payload_axis_tvalid(tv[1]), .tx_s_eth_payload_axis_tready(tready),
    .tx_s_eth_payload_axis_tlast(tl[1]), .tx_s_eth_payload_axis_tuser(tu[1]), .valid(vld[1]));

  eth_frame_write_func #(.DATA_WIDTH(32), .LEN_WIDTH(16), .PAD_EN(0), .MIN_LEN(46)) u_c (
    .clk(clk), .rst(rst), .start(st[2]), .ready(rdy[2]),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type), .payload_len(payload_len),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tuser(in_tuser), .in_tready(itr[2]),
    .tx_busy(tx_busy), .tx_s_eth_hdr_valid(hv[2]), .tx_s_eth_hdr_ready(hdr_ready),
    .tx_s_eth_dest_mac(dm[2]), .tx_s_eth_src_mac(sm[2]), .tx_s_eth_type(ty[2]),
    .tx_s_eth_payload_axis_tdata(td_c), .tx_s_eth_payload_axis_tkeep(kp_c),
    .tx_s_eth_payload_axis_tvalid(tv[2]), .tx_s_eth_payload_axis_tready(tready),
    .tx_s_eth_payload_axis_tlast(tl[2]), .tx_s_eth_payload_axis_tuser(tu[2]), .valid(vld[2]));

  // View of whichever instance the current frame targets, widened to 32 bits.
  int          sel;
  logic [31:0] m_td;
  logic [3:0]  m_kp;
  logic        m_tv, m_tl, m_tu, m_hv, m_itr, m_vld, m_rdy;
  logic [47:0] m_dm, m_sm;
  logic [15:0] m_ty;
  always_comb begin
    m_td = td_b;
    m_kp = kp_b;
    if (sel == 0) begin
      m_td = {24'h0, td_a};
      m_kp = {3'h0, kp_a};
    end else if (sel == 2) begin
      m_td = td_c;
      m_kp = kp_c;
    end
    m_tv  = tv[sel];
    m_tl  = tl[sel];
    m_tu  = tu[sel];
    m_hv  = hv[sel];
    m_itr = itr[sel];
    m_vld = vld[sel];
    m_rdy = rdy[sel];
    m_dm  = dm[sel];
    m_sm  = sm[sel];
    m_ty  = ty[sel];
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    int inst;
    int len;
    int wbase;
    int nwords;
    int tuser_word;
    int ebase;
    int nb;
    int accepts;
    bit stall;
  } case_t;

  localparam int NCASES = 7;
  case_t       cases [NCASES];
  logic [31:0] words [15];
  beat_t       exp_b [26];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    return {d, k, l, u};
  endfunction

  task automatic run_case(input int k);
    case_t        c;
    beat_t        got[$];
    beat_t        cur, prev_b;
    logic [111:0] hdr_exp, cur_h, prev_h;
    bit           stall_b, stall_h, done;
    int           widx, acc, itr_hi, cyc, t_hv, t_hf, t_first, t_last, t_valid;
    c = cases[k];
    sel = c.inst;
    widx = 0; acc = 0; itr_hi = 0;
    t_hv = -1; t_hf = -1; t_first = -1; t_last = -1; t_valid = -1;
    stall_b = 1'b0; stall_h = 1'b0; done = 1'b0;
    prev_b = '0; prev_h = '0;
    hdr_exp = {48'h0200_0000_0100 + 48'(k), 48'h0A00_0000_0200 + 48'(k), 16'h0800 + 16'(k)};
    @(negedge clk);
    {dest_mac, src_mac, eth_type} = hdr_exp;
    payload_len = 16'(c.len);
    st = 3'b000;
    st[c.inst] = 1'b1;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc == 1) begin
        st = 3'b000;
        {dest_mac, src_mac, eth_type} = '1;
        payload_len = '1;
      end
      in_tvalid = c.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_tdata  = (widx < c.nwords) ? words[c.wbase + widx] : 32'hDEAD_BEEF;
      in_tuser  = (widx == c.tuser_word);
      hdr_ready = c.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tready    = c.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      cur   = {m_td, m_kp, m_tl, m_tu};
      cur_h = {m_dm, m_sm, m_ty};
      if (cyc == 0) chk($sformatf("c%0d_ready_idle", k), 128'(m_rdy), 128'(1'b1));
      if (m_hv && t_hv < 0) t_hv = cyc;
      if (stall_h) chk($sformatf("c%0d_hdr_hold", k), 128'({m_hv, cur_h}), 128'({1'b1, prev_h}));
      if (stall_b) chk($sformatf("c%0d_beat_hold", k), 128'({m_tv, cur}), 128'({1'b1, prev_b}));
      if (m_itr) itr_hi++;
      if (m_hv && hdr_ready) begin
        t_hf = cyc;
        chk($sformatf("c%0d_hdr_fields", k), 128'(cur_h), 128'(hdr_exp));
      end
      if (m_tv && tready) begin
        if (t_first < 0) t_first = cyc;
        if (m_tl) t_last = cyc;
        got.push_back(cur);
      end
      if (m_itr && in_tvalid) begin
        widx++;
        acc++;
      end
      if (m_vld) begin
        t_valid = cyc;
        done = 1'b1;
      end
      stall_h = m_hv && !hdr_ready;
      stall_b = m_tv && !tready;
      prev_h = cur_h;
      prev_b = cur;
      @(negedge clk);
    end
    #1;
    chk($sformatf("c%0d_frame_done", k), 128'(done), 128'(1'b1));
    chk($sformatf("c%0d_valid_pulse_end", k), 128'({m_vld, m_rdy, m_hv}), 128'(3'b010));
    chk($sformatf("c%0d_hdr_latency", k), 128'(t_hv), 128'(1));
    chk($sformatf("c%0d_valid_after_last", k), 128'(t_valid), 128'(t_last + 1));
    chk($sformatf("c%0d_accepts", k), 128'(acc), 128'(c.accepts));
    chk($sformatf("c%0d_beat_count", k), 128'(got.size()), 128'(c.nb));
    for (int i = 0; i < got.size() && i < c.nb; i++)
      chk($sformatf("c%0d_beat%0d", k, i), 128'(got[i]), 128'(exp_b[c.ebase + i]));
    if (!c.stall) begin
      chk($sformatf("c%0d_first_beat_lat", k), 128'(t_first), 128'(t_hf + 1));
      chk($sformatf("c%0d_throughput", k), 128'(t_last - t_first), 128'(c.nb - 1));
      chk($sformatf("c%0d_in_tready_cycles", k), 128'(itr_hi), 128'(c.accepts));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st = 3'b000; tx_busy = 1'b0; sel = 0;
    in_tvalid = 1'b0; in_tdata = '0; in_tuser = 1'b0; hdr_ready = 1'b0; tready = 1'b0;
    dest_mac = '0; src_mac = '0; eth_type = '0; payload_len = '0;

    words = '{32'h11, 32'h22, 32'h33, 32'h4433_2211, 32'hAABB_6655, 32'h4433_2211,
              32'hDD77_6655, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h5A, 32'h6B, 32'h7C, 32'h8D};
    exp_b[0]  = mk(32'h11, 4'h1, 1'b0, 1'b0);
    exp_b[1]  = mk(32'h22, 4'h1, 1'b0, 1'b0);
    exp_b[2]  = mk(32'h33, 4'h1, 1'b1, 1'b0);
    exp_b[3]  = mk(32'h4433_2211, 4'hF, 1'b0, 1'b0);
    exp_b[4]  = mk(32'h0000_6655, 4'hF, 1'b0, 1'b0);
    for (int i = 5; i < 14; i++) exp_b[i] = mk(32'h0, 4'hF, 1'b0, 1'b0);
    exp_b[14] = mk(32'h0, 4'h3, 1'b1, 1'b0);
    exp_b[15] = mk(32'h4433_2211, 4'hF, 1'b0, 1'b0);
    exp_b[16] = mk(32'h0077_6655, 4'h7, 1'b1, 1'b0);
    exp_b[17] = mk(32'hA1, 4'h1, 1'b0, 1'b0);
    exp_b[18] = mk(32'hA2, 4'h1, 1'b0, 1'b0);
    exp_b[19] = mk(32'hA3, 4'h1, 1'b0, 1'b0);
    exp_b[20] = mk(32'hA4, 4'h1, 1'b1, 1'b1);
    exp_b[21] = mk(32'h5A, 4'h1, 1'b0, 1'b0);
    exp_b[22] = mk(32'h6B, 4'h1, 1'b0, 1'b0);
    exp_b[23] = mk(32'h7C, 4'h1, 1'b0, 1'b0);
    exp_b[24] = mk(32'h8D, 4'h1, 1'b1, 1'b0);
    exp_b[25] = mk(32'h0, 4'h1, 1'b1, 1'b0);
    //            inst len wbase nw tuser ebase nb acc stall
    cases[0] = '{0, 3, 0,  3, -1, 0,  3,  3, 1'b0};
    cases[1] = '{1, 6, 3,  2, -1, 3,  12, 2, 1'b0};
    cases[2] = '{2, 7, 5,  2, -1, 15, 2,  2, 1'b0};
    cases[3] = '{0, 4, 7,  4, 1,  17, 4,  4, 1'b0};
    cases[4] = '{0, 4, 11, 4, -1, 21, 4,  4, 1'b1};
    cases[5] = '{1, 6, 3,  2, -1, 3,  12, 2, 1'b1};
    cases[6] = '{2, 0, 0,  0, -1, 25, 1,  0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 128'(rdy), 128'(3'b111));
    chk("rst_ctrl", 128'({hv, tv, tl, tu, vld, itr}), 128'(0));
    chk("rst_regs", 128'({td_a, td_b, td_c, kp_a, kp_b, kp_c, dm[0], sm[1], ty[2]}), 128'(0));
    tx_busy = 1'b1;
    #1 chk("rst_ready_busy", 128'(rdy), 128'(3'b000));
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // start while the tx core is busy is not accepted
    @(negedge clk);
    tx_busy = 1'b1; st = 3'b001; payload_len = 16'd3;
    repeat (3) begin
      #1 chk("busy_ready", 128'(rdy[0]), 128'(1'b0));
      @(negedge clk);
      #1 chk("busy_no_hdr", 128'(hv[0]), 128'(1'b0));
    end
    st = 3'b000; tx_busy = 1'b0;
    @(negedge clk);
    #1 chk("busy_release_idle", 128'({hv[0], rdy[0]}), 128'(2'b01));

    for (int k = 0; k < NCASES; k++) run_case(k);

    // Reset while beat 2 of 5 is on the bus, then a clean frame
    sel = 0;
    @(negedge clk);
    payload_len = 16'd5; st = 3'b001; in_tvalid = 1'b1; in_tdata = 32'h5A;
    in_tuser = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
    @(negedge clk);
    st = 3'b000;
    repeat (2) @(negedge clk);
    #1 chk("mid_frame_beat", 128'({tv[0], td_a}), 128'({1'b1, 8'h5A}));
    rst = 1'b1;
    #1;
    chk("rst_async_drop", 128'({hv[0], tv[0], vld[0], itr[0], tl[0], td_a}), 128'(0));
    chk("rst_async_ready", 128'(rdy[0]), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("post_rst_idle", 128'({rdy[0], hv[0], tv[0]}), 128'(3'b100));
    run_case(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
